// File: rtl/ase_umsg_tx.sv
// Emulator-side UMsg transmitter: per-slot hint/data delay FSMs feeding a
// round-robin arbiter and a single Rx0 output register with valid/ready.
module ase_umsg_tx #(
   parameter int NUM_UMSG   = 8,
   parameter int TIMER_W    = 6,
   parameter int HINT_DELAY = 12,
   parameter int DATA_DELAY = 20,
   localparam int ID_W      = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ID_W-1:0]       cmd_id,
   input  logic                  cmd_hint,
   input  logic [511:0]          cmd_data,
   input  logic [NUM_UMSG-1:0]   hint_enable,
   output logic                  umsg_valid,
   input  logic                  umsg_ready,
   output logic [27:0]           umsg_hdr,
   output logic [511:0]          umsg_data,
   output logic [NUM_UMSG-1:0]   slot_busy,
   output logic [3*NUM_UMSG-1:0] o_dbg_state
);

   // Handshakes: cmd moves on a clock edge where cmd_valid && cmd_ready;
   // a packet moves where umsg_valid && umsg_ready. Packet fields hold while
   // umsg_valid && !umsg_ready.

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_HINT_WAIT = 3'd1,
      S_SEND_HINT = 3'd2,
      S_DATA_WAIT = 3'd3,
      S_SEND_DATA = 3'd4
   } state_t;

   typedef struct packed {
      logic [1:0] vc_used;
      logic       rsvd1;
      logic       poison;
      logic [3:0] rsvd0;
      logic [3:0] resp_type;
      logic       umsg_type;
      logic [8:0] rsvd2;
      logic [5:0] umsg_id;
   } umsg_hdr_t;

   state_t             r_state [NUM_UMSG];
   logic [TIMER_W-1:0] r_timer [NUM_UMSG];
   logic [511:0]       r_line  [NUM_UMSG];
   logic [ID_W-1:0]    r_rr_ptr;
   logic               r_valid;
   umsg_hdr_t          r_hdr;
   logic [511:0]       r_data;

   logic [NUM_UMSG-1:0] w_req;
   logic                w_accept;
   logic                w_load;
   logic                w_found;
   logic                w_grant;
   logic                w_gnt_hint;
   logic [ID_W-1:0]     w_gnt_id;
   logic [ID_W-1:0]     w_idx;

   assign cmd_ready = (r_state[cmd_id] == S_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_load    = !r_valid || umsg_ready;

   always_comb begin
      w_req       = '0;
      slot_busy   = '0;
      o_dbg_state = '0;
      for (int i = 0; i < NUM_UMSG; i++) begin
         w_req[i]              = (r_state[i] == S_SEND_HINT) || (r_state[i] == S_SEND_DATA);
         slot_busy[i]          = (r_state[i] != S_IDLE);
         o_dbg_state[3*i +: 3] = r_state[i];
      end
   end

   // Rotating search from r_rr_ptr; the first requester found wins.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_UMSG; k++) begin
         w_idx = r_rr_ptr + ID_W'(k);
         if (!w_found && w_req[w_idx]) begin
            w_found  = 1'b1;
            w_gnt_id = w_idx;
         end
      end
   end

   assign w_grant    = w_found && w_load;
   assign w_gnt_hint = (r_state[w_gnt_id] == S_SEND_HINT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_UMSG; i++) begin
            r_state[i] <= S_IDLE;
            r_timer[i] <= '0;
            r_line[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_UMSG; i++) begin
            case (r_state[i])
               S_IDLE: begin
                  if (w_accept && (cmd_id == ID_W'(i))) begin
                     r_line[i] <= cmd_data;
                     if (cmd_hint && hint_enable[i]) begin
                        r_state[i] <= S_HINT_WAIT;
                        r_timer[i] <= TIMER_W'(HINT_DELAY);
                     end else begin
                        r_state[i] <= S_DATA_WAIT;
                        r_timer[i] <= TIMER_W'(DATA_DELAY);
                     end
                  end
               end
               S_HINT_WAIT: begin
                  if (r_timer[i] == '0) r_state[i] <= S_SEND_HINT;
                  else                  r_timer[i] <= r_timer[i] - TIMER_W'(1);
               end
               S_DATA_WAIT: begin
                  if (r_timer[i] == '0) r_state[i] <= S_SEND_DATA;
                  else                  r_timer[i] <= r_timer[i] - TIMER_W'(1);
               end
               S_SEND_HINT: begin
                  if (w_grant && (w_gnt_id == ID_W'(i))) begin
                     r_state[i] <= S_DATA_WAIT;
                     r_timer[i] <= TIMER_W'(DATA_DELAY);
                  end
               end
               S_SEND_DATA: begin
                  if (w_grant && (w_gnt_id == ID_W'(i))) r_state[i] <= S_IDLE;
               end
               default: r_state[i] <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
         r_valid  <= 1'b0;
         r_hdr    <= '0;
         r_data   <= '0;
      end else if (w_grant) begin
         r_rr_ptr        <= w_gnt_id + ID_W'(1);
         r_valid         <= 1'b1;
         r_hdr           <= '0;
         r_hdr.resp_type <= 4'hF;
         r_hdr.umsg_type <= w_gnt_hint;
         r_hdr.umsg_id   <= 6'(w_gnt_id);
         r_data          <= w_gnt_hint ? 512'd0 : r_line[w_gnt_id];
      end else if (umsg_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign umsg_valid = r_valid;
   assign umsg_hdr   = r_hdr;
   assign umsg_data  = r_data;

endmodule

// File: tb/tb_ase_umsg_tx.sv
// Directed bench for ase_umsg_tx: expected packets are queued by the stimulus,
// a monitor pops and compares them on every handshake.
module tb_ase_umsg_tx;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int HD = 12;
  localparam int DD = 20;
  localparam int EW = 32 + 28 + 512;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IW-1:0]  cmd_id = '0;
  logic           cmd_hint = 1'b0;
  logic [511:0]   cmd_data = '0;
  logic [N-1:0]   hint_enable = '0;
  logic           umsg_valid;
  logic           umsg_ready = 1'b1;
  logic [27:0]    umsg_hdr;
  logic [511:0]   umsg_data;
  logic [N-1:0]   slot_busy;
  logic [3*N-1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  logic [EW-1:0] exp_q[$];

  ase_umsg_tx #(.NUM_UMSG(N), .TIMER_W(6), .HINT_DELAY(HD), .DATA_DELAY(DD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
    .cmd_hint(cmd_hint), .cmd_data(cmd_data), .hint_enable(hint_enable),
    .umsg_valid(umsg_valid), .umsg_ready(umsg_ready),
    .umsg_hdr(umsg_hdr), .umsg_data(umsg_data),
    .slot_busy(slot_busy), .o_dbg_state(dbg_state)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // {vc 2, rsvd 1, poison 1, rsvd 4, resp_type 4, umsg_type 1, rsvd 9, id 6}
  function automatic logic [27:0] mk_hdr(input int id, input logic t);
    logic [5:0] id6;
    id6 = 6'(id);
    return {8'h00, 4'hF, t, 9'h000, id6};
  endfunction

  task automatic push(input int e, input logic [27:0] h, input logic [511:0] d);
    exp_q.push_back({32'(e), h, d});
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  // with acc = edge count of the accepting clock edge.
  task automatic send_cmd(input int id, input logic hint, input logic [511:0] d, output int acc);
    int guard;
    cmd_valid = 1'b1;
    cmd_id    = IW'(id);
    cmd_hint  = hint;
    cmd_data  = d;
    #1;
    guard = 0;
    while (!cmd_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept_timeout id=%0d act=stalled exp=accepted", id);
    end
    @(posedge clk);
    @(negedge clk);
    acc = edge_cnt;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_edge(input int t);
    if (edge_cnt > t) begin
      n_cmp++; n_err++;
      $display("FAIL schedule act=%0d exp<=%0d", edge_cnt, t);
    end
    while (edge_cnt < t) @(negedge clk);
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    logic          prev_stall;
    logic [27:0]   prev_hdr;
    logic [511:0]  prev_data;
    int            e_edge;
    prev_stall = 1'b0;
    prev_hdr   = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (umsg_valid && umsg_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pkt edge=%0d hdr act=%h exp=none", edge_cnt, umsg_hdr);
          end else begin
            e = exp_q.pop_front();
            e_edge = int'(e[EW-1 -: 32]);
            if (edge_cnt != e_edge || umsg_hdr !== e[539:512] || umsg_data !== e[511:0]) begin
              n_err++;
              $display("FAIL pkt edge act=%0d exp=%0d hdr act=%h exp=%h data act=%h exp=%h",
                       edge_cnt, e_edge, umsg_hdr, e[539:512], umsg_data, e[511:0]);
            end
          end
        end
        if (umsg_valid && !umsg_ready && prev_stall) begin
          n_cmp++;
          if (umsg_hdr !== prev_hdr || umsg_data !== prev_data) begin
            n_err++;
            $display("FAIL stall_hold hdr act=%h exp=%h data act=%h exp=%h",
                     umsg_hdr, prev_hdr, umsg_data, prev_data);
          end
        end
        prev_stall = umsg_valid && !umsg_ready;
        prev_hdr   = umsg_hdr;
        prev_data  = umsg_data;
      end
    end
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog act=timeout exp=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // stimulus
  initial begin
    int a, b, c, r;
    logic [511:0] d;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 512'(umsg_valid), 512'd0);
    chk("rst_hdr",   512'(umsg_hdr),   512'd0);
    chk("rst_data",  umsg_data,        512'd0);
    chk("rst_busy",  512'(slot_busy),  512'd0);
    chk("rst_ready", 512'(cmd_ready),  512'd1);
    @(negedge clk);
    rst_n = 1'b1;
    umsg_ready = 1'b1;

    // data-only, slot 3
    d = {64{8'hA5}};
    send_cmd(3, 1'b0, d, a);
    push(a + DD + 2, mk_hdr(3, 1'b0), d);
    wait_edge(a + DD + 1); #1;
    chk("busy3_set", 512'(slot_busy[3]), 512'd1);
    wait_edge(a + DD + 2); #1;
    chk("busy3_clr", 512'(slot_busy[3]), 512'd0);
    wait_edge(a + DD + 4);

    // hint mode on slot 1; hint_enable is only sampled at accept
    hint_enable = 8'h02;
    d = {16{32'h1111_2222}};
    send_cmd(1, 1'b1, d, a);
    hint_enable = 8'h00;
    push(a + HD + 2, mk_hdr(1, 1'b1), 512'd0);
    push(a + HD + DD + 4, mk_hdr(1, 1'b0), d);
    wait_edge(a + HD + DD + 6);

    // hint requested but disabled
    d = {16{32'h3333_4444}};
    send_cmd(1, 1'b1, d, a);
    push(a + DD + 2, mk_hdr(1, 1'b0), d);
    wait_edge(a + DD + 4);

    // backpressure: 10 stalled cycles on slot 2
    umsg_ready = 1'b0;
    d = {16{32'h2222_0000}};
    send_cmd(2, 1'b0, d, a);
    push(a + DD + 12, mk_hdr(2, 1'b0), d);
    wait_edge(a + DD + 12);
    umsg_ready = 1'b1;
    wait_edge(a + DD + 14); #1;
    chk("bp_single_hs", 512'(umsg_valid), 512'd0);

    // slots 2 and 5 both waiting in SendData with rr_ptr at 3
    @(negedge clk);
    umsg_ready = 1'b0;
    d = {16{32'h2222_AAAA}};
    send_cmd(2, 1'b0, d, a);
    r = a + 60;
    push(r, mk_hdr(2, 1'b0), d);
    wait_edge(a + DD + 2);
    send_cmd(2, 1'b0, {16{32'h2222_BBBB}}, b);
    send_cmd(5, 1'b0, {16{32'h5555_CCCC}}, c);
    push(r + 1, mk_hdr(5, 1'b0), {16{32'h5555_CCCC}});
    push(r + 2, mk_hdr(2, 1'b0), {16{32'h2222_BBBB}});
    wait_edge(r);
    umsg_ready = 1'b1;
    wait_edge(r + 4);

    // all eight slots back to back
    for (int i = 0; i < N; i++) begin
      d = {64{8'(8'h10 + i)}};
      send_cmd(i, 1'b0, d, a);
      push(a + DD + 2, mk_hdr(i, 1'b0), d);
    end
    wait_edge(a + DD + 4);

    // busy slot 4 stalls the second command until its data grant
    d = {16{32'h4444_0001}};
    send_cmd(4, 1'b0, d, a);
    push(a + DD + 2, mk_hdr(4, 1'b0), d);
    d = {16{32'h4444_0002}};
    send_cmd(4, 1'b0, d, b);
    chk("busy4_accept_edge", 512'(b), 512'(a + DD + 3));
    push(b + DD + 2, mk_hdr(4, 1'b0), d);
    wait_edge(b + DD + 4);

    // reset while slot 6 is in DataWait and an undelivered packet is held
    umsg_ready = 1'b0;
    send_cmd(6, 1'b0, {16{32'h6666_0001}}, a);
    wait_edge(a + DD + 2);
    send_cmd(6, 1'b0, {16{32'h6666_0002}}, b);
    wait_edge(b + 5); #1;
    chk("pre_rst_valid", 512'(umsg_valid), 512'd1);
    chk("pre_rst_busy",  512'(slot_busy),  512'h40);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_valid", 512'(umsg_valid), 512'd0);
    chk("mid_rst_hdr",   512'(umsg_hdr),   512'd0);
    chk("mid_rst_data",  umsg_data,        512'd0);
    chk("mid_rst_busy",  512'(slot_busy),  512'd0);
    chk("mid_rst_ready", 512'(cmd_ready),  512'd1);
    @(negedge clk);
    rst_n = 1'b1;
    umsg_ready = 1'b1;
    repeat (40) @(negedge clk);

    chk("queue_drained", 512'(exp_q.size()), 512'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
